// File: rtl/uart_rx_pkg.sv
// UART receive core shared types.
// FSM states, parity modes and error-flag bit positions.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_CRC,
        ST_STOP1,
        ST_STOP2
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int ERR_PAR = 0;
    localparam int ERR_CRC = 1;
    localparam int ERR_FRM = 2;
    localparam int ERR_OVR = 3;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_crc_serial.sv
// Bit-serial CRC accumulator, MSB-side feedback.
// Cleared by init_i, advances one bit per en_i.
module uart_crc_serial #(
    parameter int               CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(8'h07)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic fb;

    assign fb = crc_o[CRC_W-1] ^ bit_i;

    // Shift the remainder and fold in the polynomial on feedback.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_o <= '0;
        end else if (init_i) begin
            crc_o <= '0;
        end else if (en_i) begin
            crc_o <= {crc_o[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/uart_rx_core_p.sv
// Parametrised UART receiver: sync, FSM, mid-bit sampling,
// parity/CRC checks and valid/ready output with overrun.
import uart_rx_pkg::*;

module uart_rx_core_p #(
    parameter int               DATA_W   = 8,
    parameter int               CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(8'h07),
    parameter int               OVS      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              tick_i,
    input  logic [1:0]        parity_mode_i,
    input  logic              crc_en_i,
    input  logic              two_stop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              err_int_o,
    output logic [3:0]        err_flags_o,
    output logic              busy_o
);

    localparam int BIT_MAX = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int BCW     = $clog2(BIT_MAX + 1);
    localparam int TCW     = $clog2(OVS);

    localparam logic [TCW-1:0] T_HALF = TCW'(OVS / 2 - 1);
    localparam logic [TCW-1:0] T_FULL = TCW'(OVS - 1);
    localparam logic [BCW-1:0] B_DATA = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] B_CRC  = BCW'(CRC_W - 1);

    rx_state_e          state_q;
    rx_state_e          state_d;
    logic               rx_q;
    logic               rx_s;
    logic [TCW-1:0]     tick_cnt;
    logic [BCW-1:0]     bit_cnt;
    logic               armed;
    logic [1:0]         cfg_par;
    logic               cfg_crc;
    logic               cfg_two;
    logic [DATA_W-1:0]  data_sh;
    logic [CRC_W-1:0]   crc_rx;
    logic [CRC_W-1:0]   crc_calc;
    logic               par_err;
    logic               frm_err;

    logic               half_hit;
    logic               bit_hit;
    logic               bit_step;
    logic               frame_end;
    logic               par_exp;
    logic               frm_now;
    logic               crc_bad;
    logic               good;
    logic               ovr;
    logic [3:0]         flags_new;

    assign half_hit = tick_i && (tick_cnt == T_HALF);
    assign bit_hit  = tick_i && (tick_cnt == T_FULL);
    assign par_exp  = (cfg_par == PAR_ODD) ? ~^data_sh : ^data_sh;
    assign frm_now  = frm_err | ~rx_s;
    assign crc_bad  = cfg_crc && (crc_rx != crc_calc);
    assign good     = !frm_now && !crc_bad && !par_err;
    assign ovr      = good && rx_valid_o && !rx_ready_i;
    assign busy_o   = (state_q != ST_IDLE);

    always_comb begin
        flags_new          = '0;
        flags_new[ERR_OVR] = ovr;
        flags_new[ERR_FRM] = frm_now;
        flags_new[ERR_CRC] = crc_bad;
        flags_new[ERR_PAR] = par_err;
    end

    // Two-flop synchroniser; idles high so reset looks like a quiet line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_q <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_q <= rx_i;
            rx_s <= rx_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode; only tick cycles can move the FSM.
    always_comb begin
        state_d   = state_q;
        bit_step  = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tick_i && armed && !rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (half_hit) state_d = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_hit) begin
                    if (bit_cnt == B_DATA) begin
                        if (cfg_crc)                  state_d = ST_CRC;
                        else if (par_enabled(cfg_par)) state_d = ST_PARITY;
                        else                          state_d = ST_STOP1;
                    end else begin
                        bit_step = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_hit) state_d = ST_STOP1;
            end
            ST_CRC: begin
                if (bit_hit) begin
                    if (bit_cnt == B_CRC) state_d = ST_STOP1;
                    else                  bit_step = 1'b1;
                end
            end
            ST_STOP1: begin
                if (bit_hit) begin
                    if (cfg_two) begin
                        state_d = ST_STOP2;
                    end else begin
                        state_d   = ST_IDLE;
                        frame_end = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (bit_hit) begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tick/bit counters restart on every state change and per bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_d != state_q) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (tick_i && state_q != ST_IDLE) begin
            tick_cnt <= bit_hit ? '0 : tick_cnt + TCW'(1);
            if (bit_step) bit_cnt <= bit_cnt + BCW'(1);
        end
    end

    // Arm start detection only after the line is seen high (break guard).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (state_d == ST_START)  armed <= 1'b0;
            else if (tick_i && rx_s)  armed <= 1'b1;
        end
    end

    // Frame config latch, shift registers and per-frame error state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_par <= PAR_NONE;
            cfg_crc <= 1'b0;
            cfg_two <= 1'b0;
            data_sh <= '0;
            crc_rx  <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            cfg_par <= parity_mode_i;
            cfg_crc <= crc_en_i;
            cfg_two <= two_stop_i;
            crc_rx  <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else if (bit_hit) begin
            if (state_q == ST_DATA)
                data_sh <= {rx_s, data_sh[DATA_W-1:1]};
            if (state_q == ST_CRC)
                crc_rx <= {rx_s, crc_rx[CRC_W-1:1]};
            if (state_q == ST_PARITY)
                par_err <= (rx_s != par_exp);
            if (state_q == ST_STOP1 && !rx_s)
                frm_err <= 1'b1;
        end
    end

    uart_crc_serial #(
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY)
    ) u_crc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .init_i (state_q == ST_IDLE),
        .en_i   (state_q == ST_DATA && bit_hit),
        .bit_i  (rx_s),
        .crc_o  (crc_calc)
    );

    // Frame result, error pulse and valid/ready output handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o      <= '0;
            rx_valid_o  <= 1'b0;
            err_int_o   <= 1'b0;
            err_flags_o <= '0;
        end else begin
            err_int_o <= 1'b0;
            if (frame_end) begin
                err_flags_o <= flags_new;
                err_int_o   <= |flags_new;
            end
            if (frame_end && good && (!rx_valid_o || rx_ready_i)) begin
                data_o     <= data_sh;
                rx_valid_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core_p.sv
// Directed bench for uart_rx_core_p: table of frames plus
// glitch, overrun and mid-frame reset sequences.
module tb_uart_rx_core_p;

    localparam int OVS = 16;

    logic       clk;
    logic       rst_ni;
    logic       rx;
    logic       tick;
    logic [1:0] pmode;
    logic       crc_en;
    logic       two_stop;
    logic [7:0] data_o;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_int;
    logic [3:0] err_flags;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int   vcnt = 0;
    int   phi = 0;
    int   prise = 0;
    logic prev_int = 1'b0;

    uart_rx_core_p #(
        .DATA_W   (8),
        .CRC_W    (8),
        .CRC_POLY (8'h07),
        .OVS      (OVS)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .rx_i          (rx),
        .tick_i        (tick),
        .parity_mode_i (pmode),
        .crc_en_i      (crc_en),
        .two_stop_i    (two_stop),
        .data_o        (data_o),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .err_int_o     (err_int),
        .err_flags_o   (err_flags),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) vcnt++;
        if (err_int) phi++;
        if (err_int && !prev_int) prise++;
        prev_int = err_int;
    end

    typedef struct {
        logic [1:0] pm;
        logic       ce;
        logic       ts;
        logic [7:0] d;
        logic       pflip;
        logic [7:0] cxor;
        logic       s1;
        logic       s2;
        int         exp_v;
        logic [3:0] exp_f;
        int         exp_p;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        cyc(OVS);
    endtask

    // CRC as remainder of m(x)*x^8 mod (x^8+x^2+x+1), first bit = MSB.
    function automatic logic [7:0] crc_model(input logic [7:0] d);
        logic [15:0] v;
        logic [7:0]  m;
        for (int i = 0; i < 8; i++) m[7-i] = d[i];
        v = {m, 8'h00};
        for (int k = 15; k >= 8; k--)
            if (v[k]) v = v ^ (16'h0107 << (k - 8));
        return v[7:0];
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm,
                              input logic ce, input logic ts,
                              input logic pflip, input logic [7:0] cxor,
                              input logic s1, input logic s2);
        logic [7:0] c;
        logic       p;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (ce) begin
            c = crc_model(d) ^ cxor;
            for (int i = 0; i < 8; i++) drive_bit(c[i]);
        end else if (pm == 2'b01 || pm == 2'b10) begin
            p = (pm == 2'b01) ? ~^d : ^d;
            drive_bit(p ^ pflip);
        end
        drive_bit(s1);
        if (ts) drive_bit(s2);
        rx = 1'b1;
    endtask

    initial begin
        int v0, p0, h0;

        vecs[0] = '{2'b00, 0, 0, 8'hA5, 0, 8'h00, 1, 1, 1, 4'b0000, 0, 8'hA5};
        vecs[1] = '{2'b01, 0, 0, 8'hA5, 0, 8'h00, 1, 1, 1, 4'b0000, 0, 8'hA5};
        vecs[2] = '{2'b01, 0, 0, 8'hA5, 1, 8'h00, 1, 1, 0, 4'b0001, 1, 8'hA5};
        vecs[3] = '{2'b00, 1, 0, 8'h3C, 0, 8'h00, 1, 1, 1, 4'b0000, 0, 8'h3C};
        vecs[4] = '{2'b00, 1, 0, 8'h3C, 0, 8'h01, 1, 1, 0, 4'b0010, 1, 8'h3C};
        vecs[5] = '{2'b10, 0, 0, 8'h5A, 0, 8'h00, 0, 1, 0, 4'b0100, 1, 8'h3C};
        vecs[6] = '{2'b00, 0, 1, 8'h81, 0, 8'h00, 1, 0, 0, 4'b0100, 1, 8'h3C};
        vecs[7] = '{2'b00, 0, 1, 8'hC3, 0, 8'h00, 1, 1, 1, 4'b0000, 0, 8'hC3};
        vecs[8] = '{2'b10, 0, 0, 8'h07, 0, 8'h00, 1, 1, 1, 4'b0000, 0, 8'h07};

        rst_ni   = 1'b0;
        rx       = 1'b1;
        tick     = 1'b1;
        pmode    = 2'b00;
        crc_en   = 1'b0;
        two_stop = 1'b0;
        rx_ready = 1'b1;
        cyc(3);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_int", 32'(err_int), 32'h0);
        check("rst_flags", 32'(err_flags), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_ni = 1'b1;
        cyc(5);

        for (int i = 0; i < 9; i++) begin
            pmode    = vecs[i].pm;
            crc_en   = vecs[i].ce;
            two_stop = vecs[i].ts;
            rx_ready = 1'b1;
            cyc(2);
            v0 = vcnt;
            p0 = prise;
            h0 = phi;
            send_frame(vecs[i].d, vecs[i].pm, vecs[i].ce, vecs[i].ts,
                       vecs[i].pflip, vecs[i].cxor, vecs[i].s1, vecs[i].s2);
            cyc(24);
            check($sformatf("v%0d_valid_cycles", i), 32'(vcnt - v0),
                  32'(vecs[i].exp_v));
            check($sformatf("v%0d_flags", i), 32'(err_flags),
                  32'(vecs[i].exp_f));
            check($sformatf("v%0d_int_pulses", i), 32'(prise - p0),
                  32'(vecs[i].exp_p));
            check($sformatf("v%0d_int_cycles", i), 32'(phi - h0),
                  32'(vecs[i].exp_p));
            check($sformatf("v%0d_data", i), 32'(data_o),
                  32'(vecs[i].exp_d));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
        end

        // Short low glitch in IDLE is a false start.
        pmode    = 2'b00;
        crc_en   = 1'b0;
        two_stop = 1'b0;
        cyc(2);
        v0 = vcnt;
        p0 = prise;
        rx = 1'b0;
        cyc(4);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        cyc(1);
        rx = 1'b1;
        cyc(30);
        check("glitch_busy", 32'(busy), 32'h0);
        check("glitch_valid", 32'(vcnt - v0), 32'h0);
        check("glitch_int", 32'(prise - p0), 32'h0);
        check("glitch_flags", 32'(err_flags), 32'h0);

        // Overrun: second good frame while first is unread.
        rx_ready = 1'b0;
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(24);
        check("ovr_first_valid", 32'(rx_valid), 32'h1);
        check("ovr_first_data", 32'(data_o), 32'h11);
        check("ovr_first_flags", 32'(err_flags), 32'h0);
        p0 = prise;
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(24);
        check("ovr_data_kept", 32'(data_o), 32'h11);
        check("ovr_flags", 32'(err_flags), 32'h8);
        check("ovr_int", 32'(prise - p0), 32'h1);
        check("ovr_valid_held", 32'(rx_valid), 32'h1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ready_valid_pre", 32'(rx_valid), 32'h1);
        @(posedge clk);
        #1;
        check("ready_valid_drop", 32'(rx_valid), 32'h0);

        // Asynchronous reset in the middle of the data bits.
        cyc(4);
        drive_bit(1'b0);
        drive_bit(1'b1);
        cyc(10);
        check("mid_busy", 32'(busy), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_o), 32'h0);
        check("mid_rst_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_flags", 32'(err_flags), 32'h0);
        check("mid_rst_int", 32'(err_int), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        cyc(3);
        rst_ni = 1'b1;
        cyc(20);
        v0 = vcnt;
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(24);
        check("post_rst_data", 32'(data_o), 32'h5A);
        check("post_rst_valid", 32'(vcnt - v0), 32'h1);
        check("post_rst_flags", 32'(err_flags), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core_p.md
Name: uart_rx_core_p

Overview:
- Parametrised successor to the current UART receive data path.
- Integrates the receive FSM, oversampled start-bit validation and mid-bit sampling in one block.
- Adds configurable data width, runtime-selectable parity (none/odd/even), optional CRC field, 1 or 2 stop bits, and a valid/ready output handshake with overrun detection.
- Sits between the RX pin synchroniser boundary and the register/interrupt interface.

Parameters:
- DATA_W, 8, data bits per frame (5..9).
- CRC_W, 8, CRC field width in bits (4..16).
- CRC_POLY, 8'h07, CRC generator polynomial, CRC_W bits wide, implicit leading 1.
- OVS, 16, oversampling ticks per bit (even, >=4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- rx_i  in  1  raw serial input, asynchronous, idle high
- tick_i  in  1  one-cycle pulse at OVS x baud rate
- parity_mode_i  in  2  00 none, 01 odd, 10 even, 11 treated as none
- crc_en_i  in  1  CRC field follows data; parity is skipped when set
- two_stop_i  in  1  expect two stop bits
- data_o  out  DATA_W  received data, LSB = first received bit
- rx_valid_o  out  1  data_o holds an unread good frame
- rx_ready_i  in  1  consumer accepts data_o
- err_int_o  out  1  one-cycle error pulse
- err_flags_o  out  4  {overrun, frame, crc, parity}, sticky until next frame end
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_ni=0, async): FSM to IDLE; all counters, shift registers and CRC cleared; data_o=0, rx_valid_o=0, err_int_o=0, err_flags_o=0, busy_o=0. Synchroniser flops reset to 1.
- rx_i passes through a 2-flop synchroniser (rx_s). All decisions use rx_s and occur only on cycles with tick_i=1.
- FSM states: IDLE, START, DATA, PARITY, CRC, STOP1, STOP2.
- IDLE:
  - rx_s=0 on a tick -> START; tick counter cleared.
  - parity_mode_i, crc_en_i and two_stop_i are latched here. Mid-frame changes have no effect.
  - CRC register initialised to all zeros.
- START:
  - After OVS/2 ticks, resample rx_s.
  - rx_s=1 -> false start: return to IDLE, no flags, no pulse.
  - rx_s=0 -> DATA.
- Sampling: in DATA/PARITY/CRC/STOP states, each bit is sampled after OVS ticks, i.e. at the bit centre.
- DATA:
  - DATA_W samples, shifted in right (LSB first).
  - Each sampled bit also updates CRC: fb = crc[CRC_W-1] ^ bit; crc = {crc[CRC_W-2:0],0} ^ (fb ? CRC_POLY : 0).
  - Exit: crc_en -> CRC; else parity_mode none -> STOP1; else -> PARITY.
- PARITY:
  - One sample.
  - Expected parity: odd -> ~^data; even -> ^data.
  - Mismatch sets the parity error.
- CRC:
  - CRC_W samples, received LSB first into a shift register.
  - Compared with the calculated CRC at stop sampling.
- STOP1:
  - rx_s=0 -> frame error.
  - -> STOP2 if two_stop, else frame end.
- STOP2: rx_s=0 -> frame error; then frame end.
- Frame end (on the final stop tick):
  - err_flags_o is replaced by {ovr, frm, crc, par} for this frame.
  - Any flag set -> err_int_o pulses exactly one cycle later.
  - Otherwise, if rx_valid_o=0: data_o loads, and rx_valid_o rises the cycle after the final stop tick.
  - Otherwise (rx_valid_o=1, unread) -> overrun flag set, err_int_o pulses, old data_o is kept, new data is dropped.
  - Errored frames never update data_o.
  - FSM returns to IDLE.
- A stop bit sampled low still leaves the FSM in IDLE. A new start is accepted only after rx_s has been seen high, which avoids a break condition retriggering.
- Handshake:
  - rx_valid_o falls the cycle after rx_valid_o & rx_ready_i.
  - data_o is stable while rx_valid_o=1.
  - If rx_ready_i is accepted on the same cycle a new good frame ends, the new data is loaded, rx_valid_o stays 1, and there is no overrun.
- Bit counter width is $clog2(max(DATA_W, CRC_W)+1). Tick counter width is $clog2(OVS). Neither counter wraps: both are cleared on every state change.
- tick_i=0 stalls all sampling. The handshake logic still runs every cycle.

Decomposition:
- Package uart_rx_pkg: FSM state enum, parity mode enum/localparams (PAR_NONE, PAR_ODD, PAR_EVEN), error-flag bit index constants.
- Sub-module uart_crc_serial (params CRC_W, CRC_POLY; ports clk_i, rst_ni, init_i, en_i, bit_i, crc_o), instantiated once.

Test Plan:
- 8N1, OVS=16, tick every cycle, send 0xA5 with rx_ready_i=1 -> data_o=0xA5, rx_valid_o high 1 cycle, err_flags_o=0.
- Odd parity, send 0xA5 with parity bit 1 -> good frame. Repeat with parity bit 0 -> err_flags_o=4'b0001, err_int_o single pulse, rx_valid_o stays 0.
- crc_en=1, send 0x3C followed by the software-model CRC -> good frame. Flip CRC bit 0 -> err_flags_o=4'b0010.
- Low glitch of 5 cycles (less than OVS/2) in IDLE -> no busy after return, no valid, no flags. Stop bit held 0 -> err_flags_o=4'b0100.
- rx_ready_i=0, send 0x11 then 0x22 -> data_o=0x11, err_flags_o=4'b1000, err_int_o pulse. Raise ready -> rx_valid_o drops the next cycle.
- two_stop=1 with second stop low -> frame error. Assert rst_ni=0 mid DATA -> all outputs 0 immediately; a following clean 0x5A frame is received correctly.
